// File: rtl/dll_lock_seq_pkg.sv
// Shared types and constants for the DLL lock sequencer.
package dll_lock_seq_pkg;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam int unsigned RETRY_W = 3;
  localparam int unsigned LOSS_W  = 8;

  localparam int unsigned DEF_RST_PULSE  = 8;
  localparam int unsigned DEF_LOCK_TMO   = 2097152;
  localparam int unsigned DEF_STABLE_CYC = 1024;
  localparam int unsigned DEF_MAX_RETRY  = 7;
  localparam int unsigned DEF_TMR_W      = 25;

endpackage

// File: rtl/dll_lock_seq_if.sv
// Control/status bundle between the lock sequencer and the DLL / downstream reset domain.
interface dll_lock_seq_if;
  import dll_lock_seq_pkg::*;

  logic               locked_in;
  logic               retrain;
  logic               dll_rst;
  logic               sys_rst;
  logic               ready;
  logic               fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [LOSS_W-1:0]  loss_cnt;

  modport master (
    input  locked_in, retrain,
    output dll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt
  );

  modport slave (
    output locked_in, retrain,
    input  dll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt
  );

endinterface

// File: rtl/dll_lock_sync.sv
// Two-flop synchroniser for the asynchronous DLL LOCKED flag; resets to "not locked".
module dll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dll_lock_seq.sv
// DLL power-up/relock sequencer: reset pulse, lock wait with timeout and retry, stability hold.
// Optional lock-loss counter enabled by defining DLL_LOCK_SEQ_LOSS_CNT_EN.
module dll_lock_seq
  import dll_lock_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE  = DEF_RST_PULSE,
  parameter int unsigned LOCK_TMO   = DEF_LOCK_TMO,
  parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
  parameter int unsigned MAX_RETRY  = DEF_MAX_RETRY,
  parameter int unsigned TMR_W      = DEF_TMR_W
) (
  input  logic           CLKIN,
  input  logic           RST,
  dll_lock_seq_if.master io
);

  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [RETRY_W-1:0] retry_q, retry_nxt;
  logic               dll_rst_q, sys_rst_q, ready_q, fail_q;
  logic               dll_rst_nxt, sys_rst_nxt, ready_nxt, fail_nxt;
  logic               lk;

  dll_lock_sync u_lock_sync (
    .clk (CLKIN),
    .rst (RST),
    .d   (io.locked_in),
    .q   (lk)
  );

  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      state     <= S_RST;
      timer     <= '0;
      retry_q   <= '0;
      dll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      retry_q   <= retry_nxt;
      dll_rst_q <= dll_rst_nxt;
      sys_rst_q <= sys_rst_nxt;
      ready_q   <= ready_nxt;
      fail_q    <= fail_nxt;
    end
  end

  // Timer only runs in the timed states so it never wraps while parked in RUN/FAIL.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    retry_nxt = retry_q;
    case (state)
      S_RST: begin
        timer_nxt = timer + TMR_W'(1);
        if (timer == TMR_W'(RST_PULSE - 1)) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        timer_nxt = timer + TMR_W'(1);
        if (io.retrain) begin
          state_nxt = S_RST;
        end else if (lk) begin
          state_nxt = S_STABLE;
        end else if (timer == TMR_W'(LOCK_TMO - 1)) begin
          retry_nxt = (retry_q == RETRY_SAT) ? retry_q : retry_q + RETRY_W'(1);
          state_nxt = (MAX_RETRY != 0 && 32'(retry_nxt) >= MAX_RETRY) ? S_FAIL : S_RST;
        end
      end
      S_STABLE: begin
        timer_nxt = timer + TMR_W'(1);
        if (io.retrain || !lk) begin
          state_nxt = S_RST;
        end else if (timer == TMR_W'(STABLE_CYC - 1)) begin
          state_nxt = S_RUN;
          retry_nxt = '0;
        end
      end
      S_RUN: begin
        if (io.retrain || !lk) state_nxt = S_RST;
      end
      S_FAIL: begin
        if (io.retrain) begin
          state_nxt = S_RST;
          retry_nxt = '0;
        end
      end
      default: state_nxt = S_RST;
    endcase
    if (state_nxt != state) timer_nxt = '0;
    dll_rst_nxt = (state_nxt == S_RST) || (state_nxt == S_FAIL);
    sys_rst_nxt = (state_nxt != S_RUN);
    ready_nxt   = (state_nxt == S_RUN);
    fail_nxt    = (state_nxt == S_FAIL);
  end

  assign io.dll_rst   = dll_rst_q;
  assign io.sys_rst   = sys_rst_q;
  assign io.ready     = ready_q;
  assign io.fail      = fail_q;
  assign io.retry_cnt = retry_q;

`ifdef DLL_LOCK_SEQ_LOSS_CNT_EN
  // Only genuine lock loss in RUN counts; a bare retrain does not.
  logic [LOSS_W-1:0] loss_q;
  logic              loss_evt;

  assign loss_evt = (state == S_RUN) && !lk;

  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      loss_q <= '0;
    end else if (loss_evt && (loss_q != '1)) begin
      loss_q <= loss_q + LOSS_W'(1);
    end
  end

  assign io.loss_cnt = loss_q;
`else
  assign io.loss_cnt = '0;
`endif

endmodule
